// File: rtl/control_unit.sv
// Multi-cycle control unit for an 8-bit accumulator CPU: drives memory and an external ALU
// through an eight-state fetch/decode/operand/execute sequence.
module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_rw,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [7:0]        alu_flags,
    input  logic [7:0]        alu_c,
    input  logic [7:0]        alu_newflags,
    output logic              halted,
    output logic [7:0]        acc_out
);

    localparam logic [2:0] StFetch   = 3'd0;
    localparam logic [2:0] StDecode  = 3'd1;
    localparam logic [2:0] StFetchOp = 3'd2;
    localparam logic [2:0] StOperand = 3'd3;
    localparam logic [2:0] StRead    = 3'd4;
    localparam logic [2:0] StExec    = 3'd5;
    localparam logic [2:0] StWrite   = 3'd6;
    localparam logic [2:0] StHalt    = 3'd7;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpSta = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpAnd = 4'h5;
    localparam logic [3:0] OpOr  = 4'h6;
    localparam logic [3:0] OpXor = 4'h7;
    localparam logic [3:0] OpNot = 4'h8;
    localparam logic [3:0] OpCmp = 4'h9;
    localparam logic [3:0] OpJmp = 4'hA;
    localparam logic [3:0] OpJeq = 4'hB;
    localparam logic [3:0] OpJgt = 4'hC;
    localparam logic [3:0] OpRsD = 4'hD;
    localparam logic [3:0] OpRsE = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam logic [3:0] AluNot = 4'd5;
    localparam logic [3:0] AluCmp = 4'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  opr_q, opr_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  flags_q, flags_d;

    logic [3:0]        ir_op;
    logic [3:0]        fetch_op;
    logic              jump_taken;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] opr_addr;

    assign ir_op    = ir_q[7:4];
    assign fetch_op = mem_q[7:4];

    // Only the opcode nibble and the two defined flag bits carry meaning.
    logic unused_bits;
    assign unused_bits = ^{ir_q[3:0], alu_newflags[7:2]};

    // Fit the 16-bit pc and 8-bit operand onto an address bus of arbitrary width.
    if (ADDR_W > 16) begin : g_pc_wide
        assign pc_addr = {{(ADDR_W - 16){1'b0}}, pc_q};
    end else if (ADDR_W == 16) begin : g_pc_exact
        assign pc_addr = pc_q;
    end else begin : g_pc_narrow
        logic unused_pc_hi;
        assign unused_pc_hi = ^pc_q[15:ADDR_W];
        assign pc_addr      = pc_q[ADDR_W-1:0];
    end

    if (ADDR_W > 8) begin : g_opr_wide
        assign opr_addr = {{(ADDR_W - 8){1'b0}}, opr_q};
    end else begin : g_opr_exact
        assign opr_addr = opr_q;
    end

    always_comb begin
        jump_taken = 1'b0;
        unique case (ir_op)
            OpJmp:   jump_taken = 1'b1;
            OpJeq:   jump_taken = flags_q[0];
            OpJgt:   jump_taken = flags_q[1];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                ir_d = mem_q;
                pc_d = pc_q + 16'd1;
                case (fetch_op)
                    OpNop, OpRsD, OpRsE: state_d = StFetch;
                    OpNot: begin
                        acc_d   = alu_c;
                        state_d = StFetch;
                    end
                    OpHlt:   state_d = StHalt;
                    default: state_d = StFetchOp;
                endcase
            end
            StFetchOp: state_d = StOperand;
            StOperand: begin
                opr_d = mem_q;
                pc_d  = pc_q + 16'd1;
                case (ir_op)
                    OpJmp, OpJeq, OpJgt: begin
                        if (jump_taken) begin
                            pc_d = {8'h00, mem_q};
                        end
                        state_d = StFetch;
                    end
                    OpSta:   state_d = StWrite;
                    default: state_d = StRead;
                endcase
            end
            StRead: state_d = StExec;
            StExec: begin
                case (ir_op)
                    OpLda:                             acc_d = mem_q;
                    OpAdd, OpSub, OpAnd, OpOr, OpXor: acc_d = alu_c;
                    OpCmp:   flags_d = {6'b0, alu_newflags[1:0]};
                    default: ;
                endcase
                state_d = StFetch;
            end
            StWrite: state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        alu_op = 4'd0;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        if (state_q == StDecode && fetch_op == OpNot) begin
            alu_op = AluNot;
            alu_a  = acc_q;
        end else if (state_q == StExec) begin
            alu_a = acc_q;
            alu_b = mem_q;
            case (ir_op)
                // ADD..XOR map onto ALU codes 0..4 by a fixed offset.
                OpAdd, OpSub, OpAnd, OpOr, OpXor: alu_op = ir_op - 4'd3;
                OpCmp:   alu_op = AluCmp;
                default: alu_op = 4'd0;
            endcase
        end
    end

    always_comb begin
        mem_addr = pc_addr;
        if (state_q == StRead || state_q == StWrite) begin
            mem_addr = opr_addr;
        end
    end

    // Gating with rst_n keeps a reset edge from also committing a pending store.
    assign mem_rw    = (state_q == StWrite) && rst_n;
    assign mem_data  = acc_q;
    assign alu_flags = flags_q;
    assign halted    = (state_q == StHalt);
    assign acc_out   = acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            opr_q   <= 8'h00;
            acc_q   <= 8'h00;
            flags_q <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, the PC value loaded at reset.
REQ-002 Parameter ADDR_W, 16, the memory address width; must be at least 8.
REQ-003 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 mem_q  in  8  registered read data from mem; valid in the cycle after its address was driven.
REQ-006 mem_addr  out  ADDR_W  memory address.
REQ-007 mem_data  out  8  write data to mem.
REQ-008 mem_rw  out  1  1 = write mem_data to mem_addr at the next edge.
REQ-009 alu_op  out  4  ALU opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, CMP=6.
REQ-010 alu_a, alu_b, alu_flags  out  8 each  ALU operands and current flags.
REQ-011 alu_c, alu_newflags  in  8 each  ALU result and result flags.
REQ-012 halted  out  1  high while in HALT.
REQ-013 acc_out  out  8  accumulator value, for debug.

Function
REQ-014 Internal registers: pc[15:0], ir[7:0], opr[7:0], acc[7:0], flags[7:0] (bit0 EQ, bit1 GRT, bits 7:2 always 0).
REQ-015 Opcode is ir[7:4]; ir[3:0] is ignored.
  - 0 NOP; 1 LDA a; 2 STA a; 3 ADD a; 4 SUB a; 5 AND a; 6 OR a; 7 XOR a; 8 NOT; 9 CMP a; A JMP a; B JEQ a; C JGT a; F HLT.
  - Codes D and E execute as NOP.
  - "a" is the 8-bit second byte, zero-extended to ADDR_W.
REQ-016 FSM states and transitions SHALL be exactly as follows:
  - FETCH: mem_addr=pc -> DECODE.
  - DECODE: ir<=mem_q; pc<=pc+1; decode uses mem_q directly.
    - NOP, D, E -> FETCH.
    - NOT: acc<=alu_c, with alu_op=5 and alu_a=acc -> FETCH.
    - HLT -> HALT.
    - Any other opcode -> FETCH_OP.
  - FETCH_OP: mem_addr=pc -> OPERAND.
  - OPERAND: opr<=mem_q; pc<=pc+1, except when a jump is taken.
    - JMP, taken JEQ/JGT: pc<={0,mem_q} -> FETCH.
    - Untaken JEQ/JGT -> FETCH.
    - STA -> WRITE.
    - All other opcodes -> READ.
  - READ: mem_addr={0,opr} -> EXEC.
  - EXEC: alu_a=acc, alu_b=mem_q, alu_op=ir[7:4]-3 for ADD..XOR, alu_op=6 for CMP.
    - LDA: acc<=mem_q.
    - ADD..XOR: acc<=alu_c.
    - CMP: flags<={6'b0, alu_newflags[1:0]}.
    - All cases -> FETCH.
  - WRITE: mem_addr={0,opr}, mem_data=acc, mem_rw=1 -> FETCH.
  - HALT: stays in HALT; no memory access; only reset exits.
REQ-017 Instruction cycle counts SHALL be: NOP/NOT/HLT 2, jumps 4, STA 5, LDA/ALU/CMP 6.
REQ-018 mem_rw SHALL equal (state==WRITE) AND rst_n, so that no write occurs on an edge where reset is asserted.
REQ-019 Outside the states listed above:
  - alu_op SHALL be 0 and alu_a/alu_b SHALL be 0.
  - alu_flags SHALL always equal flags.
  - mem_data SHALL always equal acc.
REQ-020 Arithmetic and width rules:
  - pc increments modulo 2^16, so FFFF wraps to 0000.
  - ALU results are 8-bit with carry discarded (FF+01 = 00).
  - Only CMP modifies flags.
REQ-021 JEQ is taken iff flags[0]=1; JGT is taken iff flags[1]=1; the flags sampled are those present in the OPERAND cycle.
REQ-022 mem_addr is not constrained to the memory depth; the upper bits are driven by pc.

Reset
REQ-023 When rst_n=0 at a rising edge, on the next cycle: state=FETCH, pc=RESET_PC, ir=opr=acc=flags=0.
REQ-024 Reset SHALL take priority over every state, including HALT and WRITE.
  - An instruction interrupted by reset leaves no partial register update.
  - Its memory write does not occur.
REQ-025 After release, the first fetch SHALL present mem_addr=RESET_PC in the first cycle with rst_n=1.
  - Outputs in that cycle: halted=0, mem_rw=0, acc_out=0.

Verification
REQ-026 Program at 00: 10 10 / 30 11 / 20 12 / F0, with mem[10]=05, mem[11]=07.
  - Required: mem[12]=0C; halted=1 at cycle 19 after reset release; pc=07.
REQ-027 ACC=FF (from LDA), then ADD of mem=01.
  - Required: acc=00; flags unchanged at 00.
REQ-028 CMP with acc=05, mem=05, then JEQ 40.
  - Required: flags=01; next fetch at mem_addr=0040.
  - Repeat with acc=06, mem=05: flags=02; JEQ falls through; JGT is taken.
REQ-029 rst_n driven low during the WRITE cycle of STA.
  - Required: mem contents unchanged; acc=00; mem_addr=0000 on the cycle after reset is released.
REQ-030 Opcode E0 at address 0000.
  - Required: treated as NOP; mem_addr=0001 two cycles later.
  - With pc preloaded to FFFF via RESET_PC=FFFF: the next fetch is at 0000.
